// File: rtl/sample_iter.sv
// ============================================================================
//  Module      : sample_iter
//  Description : Walks every sample position of a grid-snapped bounding box
//                in raster order, one sample per cycle, with the held triangle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [VERTS*AXIS*SIGFIG-1:0]   tri_in,
    input  logic [COLORS*SIGFIG-1:0]       color_in,
    input  logic [4*SIGFIG-1:0]            box_in,
    input  logic                           valid_in,
    input  logic [3:0]                     subsample_in,
    output logic                           in_ready,
    input  logic                           halt_in,
    output logic [VERTS*AXIS*SIGFIG-1:0]   tri_out,
    output logic [COLORS*SIGFIG-1:0]       color_out,
    output logic [2*SIGFIG-1:0]            sample_out,
    output logic                           valid_out
);

    typedef enum logic [0:0] {
        ST_WAIT = 1'b0,
        ST_TEST = 1'b1
    } state_t;

    localparam logic [SIGFIG-1:0] c_one = SIGFIG'(1);

    state_t r_state;
    state_t w_next_state;

    logic [VERTS*AXIS*SIGFIG-1:0] r_tri;
    logic [COLORS*SIGFIG-1:0]     r_color;
    logic signed [SIGFIG-1:0]     r_ll_x;
    logic signed [SIGFIG-1:0]     r_ur_x;
    logic signed [SIGFIG-1:0]     r_ur_y;
    logic signed [SIGFIG-1:0]     r_x;
    logic signed [SIGFIG-1:0]     r_y;
    logic [SIGFIG-1:0]            r_step;
    logic                         r_valid;

    logic [SIGFIG-1:0] w_sel_step;
    logic              w_accept;
    logic              w_adv_x;
    logic              w_adv_y;
    logic              w_finish;

    // Anything that is not a legal one-hot rate falls back to 1spp.
    always_comb begin
        w_sel_step = c_one << RADIX;
        case (subsample_in)
            4'b0100: w_sel_step = c_one << (RADIX - 1);
            4'b0010: w_sel_step = c_one << (RADIX - 2);
            4'b0001: w_sel_step = c_one << (RADIX - 3);
            default: w_sel_step = c_one << RADIX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The >= tests also end inverted boxes after the single sample at ll.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_adv_x      = 1'b0;
        w_adv_y      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (valid_in) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_TEST;
                end
            end
            ST_TEST: begin
                if (!halt_in) begin
                    if (r_x < r_ur_x) begin
                        w_adv_x = 1'b1;
                    end else if (r_y < r_ur_y) begin
                        w_adv_y = 1'b1;
                    end else begin
                        w_finish     = 1'b1;
                        w_next_state = ST_WAIT;
                    end
                end
            end
            default: w_next_state = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tri   <= '0;
            r_color <= '0;
            r_ll_x  <= '0;
            r_ur_x  <= '0;
            r_ur_y  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_step  <= c_one << RADIX;
            r_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tri   <= tri_in;
                r_color <= color_in;
                r_ll_x  <= box_in[SIGFIG-1:0];
                r_ur_x  <= box_in[3*SIGFIG-1:2*SIGFIG];
                r_ur_y  <= box_in[4*SIGFIG-1:3*SIGFIG];
                r_x     <= box_in[SIGFIG-1:0];
                r_y     <= box_in[2*SIGFIG-1:SIGFIG];
                r_step  <= w_sel_step;
                r_valid <= 1'b1;
            end else if (r_state == ST_WAIT) begin
                r_valid <= 1'b0;
            end
            if (w_adv_x) begin
                r_x <= r_x + r_step;
            end
            if (w_adv_y) begin
                r_x <= r_ll_x;
                r_y <= r_y + r_step;
            end
            if (w_finish) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = (r_state == ST_WAIT);
    assign tri_out    = r_tri;
    assign color_out  = r_color;
    assign sample_out = {r_y, r_x};
    assign valid_out  = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_sample_iter.sv
// Testbench for sample_iter: scoreboard of expected samples (with the triangle
// and color they belong to) checked whenever the DUT presents a valid sample.
`default_nettype none

module tb_sample_iter;

    localparam int SIGFIG = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [215:0]  tri_in = '0;
    logic [71:0]   color_in = '0;
    logic [95:0]   box_in = '0;
    logic          valid_in = 1'b0;
    logic [3:0]    subsample_in = 4'b1000;
    logic          in_ready;
    logic          halt_in = 1'b0;
    logic [215:0]  tri_out;
    logic [71:0]   color_out;
    logic [47:0]   sample_out;
    logic          valid_out;

    sample_iter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tri_in       (tri_in),
        .color_in     (color_in),
        .box_in       (box_in),
        .valid_in     (valid_in),
        .subsample_in (subsample_in),
        .in_ready     (in_ready),
        .halt_in      (halt_in),
        .tri_out      (tri_out),
        .color_out    (color_out),
        .sample_out   (sample_out),
        .valid_out    (valid_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [47:0]  s;
        logic [215:0] t;
        logic [71:0]  c;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Samples stay on the output while halted, so only pop when not halted.
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            check("busy_ready", 256'(in_ready), 256'(0));
            if (q.size() == 0) begin
                check("sb_underflow", 256'(valid_out), 256'(0));
            end else begin
                check("sample", 256'(sample_out), 256'(q[0].s));
                check("tri",    256'(tri_out),    256'(q[0].t));
                check("color",  256'(color_out),  256'(q[0].c));
                if (!halt_in) void'(q.pop_front());
            end
        end
    end

    function automatic int step_of(input logic [3:0] sub);
        case (sub)
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    task automatic send(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] sub, output int acc);
        logic [223:0] tv;
        logic [95:0]  cv;
        exp_t         e;
        int           st;
        int           guard;
        tv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        cv = {$urandom, $urandom, $urandom};
        guard = 0;
        @(posedge clk); #1;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("accept_timeout", 256'(in_ready), 256'(1));
        tri_in       = tv[215:0];
        color_in     = cv[71:0];
        box_in       = {SIGFIG'(ury), SIGFIG'(urx), SIGFIG'(lly), SIGFIG'(llx)};
        subsample_in = sub;
        valid_in     = 1'b1;
        st = step_of(sub);
        for (int y = lly; ; y += st) begin
            for (int x = llx; ; x += st) begin
                e.s = {SIGFIG'(y), SIGFIG'(x)};
                e.t = tv[215:0];
                e.c = cv[71:0];
                q.push_back(e);
                if (x >= urx) break;
            end
            if (y >= ury) break;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_idle(input int acc, input int exp_cycles);
        int n;
        n = 0;
        @(negedge clk);
        while (valid_out && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_cycle", 256'(cyc - acc), 256'(exp_cycles));
        check("ready_after", 256'(in_ready), 256'(1));
    endtask

    int a1;
    int a2;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",  256'(valid_out),  256'(0));
        check("rst_ready",  256'(in_ready),   256'(1));
        check("rst_sample", 256'(sample_out), 256'(0));
        check("rst_tri",    256'(tri_out),    256'(0));
        check("rst_color",  256'(color_out),  256'(0));
        rst_n = 1'b1;

        // 1spp 3x2 box
        send(0, 0, 2048, 1024, 4'b1000, a1);
        wait_idle(a1, 6);

        // 4spp 3x3 box
        send(0, 0, 1024, 1024, 4'b0100, a1);
        wait_idle(a1, 9);

        // halt for 3 cycles while (1024,0) is presented
        send(0, 0, 2048, 1024, 4'b1000, a1);
        @(posedge clk); #1;
        halt_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        halt_in = 1'b0;
        wait_idle(a1, 9);

        // degenerate box then an immediate second triangle
        send(-512, 3072, -512, 3072, 4'b0001, a1);
        send(0, 0, 1024, 0, 4'b1000, a2);
        check("b2b_gap", 256'(a2 - a1), 256'(2));
        wait_idle(a2, 2);

        // reset during the 3rd sample of a 16-sample box
        send(0, 0, 768, 768, 4'b0010, a1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        q.delete();
        rst_n = 1'b1;
        check("midrst_valid",  256'(valid_out),  256'(0));
        check("midrst_ready",  256'(in_ready),   256'(1));
        check("midrst_sample", 256'(sample_out), 256'(0));
        send(1024, 1024, 2048, 2048, 4'b1000, a1);
        wait_idle(a1, 4);

        // negative coordinates
        send(-2048, -1024, -1024, -1024, 4'b1000, a1);
        wait_idle(a1, 2);

        // inverted box emits a single sample at ll
        send(1024, 1024, 0, 0, 4'b0100, a1);
        wait_idle(a1, 1);

        check("sb_empty", 256'(q.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
